// File: rtl/sha_block_loader_if.sv
// sha_block_loader_if: word-stream input and block-stream output of the SHA block loader.
// The slave modport is the loader's view; master is the view of the producer/consumer.
interface sha_block_loader_if #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned WORDS  = 16
);
  logic                    in_valid;
  logic [WORD_W-1:0]       in_word;
  logic                    in_last;
  logic                    in_ready;
  logic                    blk_valid;
  logic [WORDS*WORD_W-1:0] blk_data;
  logic                    blk_first;
  logic                    blk_last;
  logic                    blk_ready;
  logic [63:0]             words_seen;

  modport master (
    output in_valid, in_word, in_last, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_first, blk_last, words_seen
  );

  modport slave (
    input  in_valid, in_word, in_last, blk_ready,
    output in_ready, blk_valid, blk_data, blk_first, blk_last, words_seen
  );
endinterface

// File: rtl/sha_block_loader.sv
// sha_block_loader: packs a stream of message words into WORDS-word blocks (word 0 in the
// MSBs) and queues up to DEPTH finished blocks for the hash core.
// Optional SHA-256 message padding is built when SHA_BLOCK_LOADER_PAD_EN is defined
// (only WORD_W=32, WORDS=16).
module sha_block_loader #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned WORDS  = 16,
  parameter int unsigned DEPTH  = 2
) (
  input logic               clk,
  input logic               rst,
  sha_block_loader_if.slave bus
);
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Slot s of a block lives in element WORDS-1-s, so slot 0 lands in the MSBs.
  typedef logic [WORDS-1:0][WORD_W-1:0] blk_t;
  typedef enum logic [1:0] {StFill, StPadZero, StPadLen} state_e;

`ifdef SHA_BLOCK_LOADER_PAD_EN
  if (WORD_W != 32 || WORDS != 16) begin : g_pad_check
    $error("sha_block_loader: padding needs WORD_W=32 and WORDS=16");
  end
`endif

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  blk_t             asm_q, asm_w, push_data;
  logic             first_q;
  logic [63:0]      words_q;
  blk_t             mem_q [DEPTH];
  logic             mfirst_q [DEPTH];
  logic             mlast_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pop, space, in_rdy, xfer, push, push_last;
`ifdef SHA_BLOCK_LOADER_PAD_EN
  logic [63:0]      len_q, len_d;
  logic             pad80_q;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A pop frees a slot on the same edge, so a full buffer can still take a push.
  assign pop    = (cnt_q != '0) & bus.blk_ready;
  assign space  = (cnt_q < CNT_W'(DEPTH)) | pop;
  assign in_rdy = ~rst & (state_q == StFill) & space;
  assign xfer   = bus.in_valid & in_rdy;

  // Decide whether a block is pushed this cycle and what it contains.
  always_comb begin
    asm_w = asm_q;
    asm_w[IDX_W'(WORDS - 1) - idx_q] = bus.in_word;
    push_data = asm_w;
    push      = 1'b0;
    push_last = 1'b0;
    state_d   = state_q;
`ifdef SHA_BLOCK_LOADER_PAD_EN
    len_d = (words_q + 64'd1) << 5;
    unique case (state_q)
      StFill: begin
        if (xfer && bus.in_last) begin
          push = 1'b1;
          // A last word in slot 15 pushes the 0x80 marker into the next block instead.
          if (idx_q != IDX_W'(15)) push_data[IDX_W'(14) - idx_q] = WORD_W'(32'h8000_0000);
          if (idx_q <= IDX_W'(12)) begin
            push_data[1] = WORD_W'(len_d[63:32]);
            push_data[0] = WORD_W'(len_d[31:0]);
            push_last    = 1'b1;
          end else begin
            state_d = StPadZero;
          end
        end else if (xfer && idx_q == IDX_W'(15)) begin
          push = 1'b1;
        end
      end
      StPadZero: state_d = StPadLen;
      StPadLen: begin
        if (space) begin
          push         = 1'b1;
          push_data    = asm_q;
          push_data[1] = WORD_W'(len_q[63:32]);
          push_data[0] = WORD_W'(len_q[31:0]);
          push_last    = 1'b1;
          state_d      = StFill;
        end
      end
      default: state_d = StFill;
    endcase
`else
    push      = xfer & (bus.in_last | (idx_q == IDX_W'(WORDS - 1)));
    push_last = bus.in_last;
`endif
  end

  // Assembly register, word counter, FSM and block FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFill;
      idx_q    <= '0;
      asm_q    <= '0;
      first_q  <= 1'b1;
      words_q  <= '0;
      mem_q    <= '{default: '0};
      mfirst_q <= '{default: 1'b0};
      mlast_q  <= '{default: 1'b0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
`ifdef SHA_BLOCK_LOADER_PAD_EN
      len_q    <= '0;
      pad80_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (xfer) begin
        asm_q   <= asm_w;
        idx_q   <= idx_q + IDX_W'(1);
        words_q <= bus.in_last ? '0 : words_q + 64'd1;
      end
      if (push) begin
        asm_q              <= '0;
        idx_q              <= '0;
        first_q            <= push_last;
        mem_q[wr_ptr_q]    <= push_data;
        mfirst_q[wr_ptr_q] <= first_q;
        mlast_q[wr_ptr_q]  <= push_last;
        wr_ptr_q           <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
`ifdef SHA_BLOCK_LOADER_PAD_EN
      if (xfer && bus.in_last) begin
        len_q   <= len_d;
        pad80_q <= (idx_q == IDX_W'(15));
      end
      if (state_q == StPadZero) begin
        asm_q <= '0;
        if (pad80_q) asm_q[15] <= WORD_W'(32'h8000_0000);
      end
`endif
    end
  end

  assign bus.in_ready   = in_rdy;
  assign bus.blk_valid  = (cnt_q != '0);
  assign bus.blk_data   = mem_q[rd_ptr_q];
  assign bus.blk_first  = mfirst_q[rd_ptr_q];
  assign bus.blk_last   = mlast_q[rd_ptr_q];
  assign bus.words_seen = words_q;
endmodule

// File: tb/tb_sha_block_loader.sv
// tb_sha_block_loader: table-driven and randomized bench for sha_block_loader with a
// message-level scoreboard. Padding checks follow SHA_BLOCK_LOADER_PAD_EN.
module tb_sha_block_loader;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned WORDS  = 16;
  localparam int unsigned DEPTH  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha_block_loader_if #(.WORD_W(WORD_W), .WORDS(WORDS)) bus ();

  sha_block_loader #(.WORD_W(WORD_W), .WORDS(WORDS), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
  } blk_s;

  typedef struct {
    int unsigned n;
    int unsigned nblk;
    logic [31:0] w0;
    logic [31:0] w5;
    logic [31:0] w15;
  } vec_s;

  int          errors = 0;
  int          checks = 0;
  blk_s        exp_q[$];
  logic [31:0] cur[$];
  int unsigned m_total = 0;
  logic        m_first = 1'b1;
  int          occ = 0;
  logic        acc_s, bv_s, ir_s;
  int unsigned pops = 0;
  blk_s        last_pop;
  logic        prev_hold = 1'b0;
  logic [511:0] prev_data;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout, want DUT progress", name);
  endtask

  function automatic logic [31:0] wd(input logic [511:0] d, input int i);
    return d[511-32*i -: 32];
  endfunction

  // Expected block from up to 16 words, unfilled slots zero.
  function automatic void emit(input logic [31:0] w[$], input logic first, input logic last);
    blk_s b;
    b.data = '0;
    for (int i = 0; i < 16; i++) if (i < w.size()) b.data[511-32*i -: 32] = w[i];
    b.first = first;
    b.last  = last;
    exp_q.push_back(b);
    occ++;
  endfunction

  // Message-level reference: full chunks go out as they fill; the tail is handled on last.
  function automatic void model_word(input logic [31:0] w, input logic last);
`ifdef SHA_BLOCK_LOADER_PAD_EN
    logic [31:0] tail[$];
    logic [31:0] chunk[$];
    logic [63:0] len;
`endif
    cur.push_back(w);
    m_total++;
    if (!last) begin
      if (cur.size() == 16) begin
        emit(cur, m_first, 1'b0);
        m_first = 1'b0;
        cur.delete();
      end
      return;
    end
`ifdef SHA_BLOCK_LOADER_PAD_EN
    len  = 64'(m_total) * 64'd32;
    tail = cur;
    tail.push_back(32'h8000_0000);
    while (tail.size() % 16 != 14) tail.push_back(32'h0);
    tail.push_back(len[63:32]);
    tail.push_back(len[31:0]);
    while (tail.size() > 0) begin
      chunk.delete();
      for (int i = 0; i < 16; i++) chunk.push_back(tail.pop_front());
      emit(chunk, m_first, tail.size() == 0);
      m_first = 1'b0;
    end
`else
    emit(cur, m_first, 1'b1);
`endif
    m_first = 1'b1;
    cur.delete();
    m_total = 0;
  endfunction

  // One clock: sample at the falling edge, then return just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    acc_s = bus.in_valid & bus.in_ready;
    bv_s  = bus.blk_valid;
    ir_s  = bus.in_ready;
    if (!rst) begin
      check("words_seen", 512'(bus.words_seen), 512'(m_total));
`ifndef SHA_BLOCK_LOADER_PAD_EN
      check("blk_valid", 512'(bus.blk_valid), 512'(occ != 0));
      check("in_ready", 512'(bus.in_ready),
            512'((occ < int'(DEPTH)) || (occ != 0 && bus.blk_ready)));
`endif
      if (prev_hold) begin
        check("hold_valid", 512'(bus.blk_valid), 512'(1'b1));
        check("hold_data", bus.blk_data, prev_data);
      end
      prev_hold = bus.blk_valid & ~bus.blk_ready;
      prev_data = bus.blk_data;
      if (bus.blk_valid && bus.blk_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: got unexpected block %0h, want none", bus.blk_data);
        end else begin
          blk_s e;
          e = exp_q.pop_front();
          check("sb_data", bus.blk_data, e.data);
          check("sb_first", 512'(bus.blk_first), 512'(e.first));
          check("sb_last", 512'(bus.blk_last), 512'(e.last));
        end
        last_pop.data  = bus.blk_data;
        last_pop.first = bus.blk_first;
        last_pop.last  = bus.blk_last;
        pops++;
        occ--;
      end
      if (acc_s) model_word(bus.in_word, bus.in_last);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic last);
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    bus.in_last  = last;
    for (int t = 0; t < 100; t++) begin
      cyc();
      if (acc_s) break;
    end
    if (!acc_s) timeout("send");
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_pops(input int unsigned target);
    for (int t = 0; t < 100 && pops < target; t++) cyc();
    if (pops < target) timeout("wait_pops");
  endtask

  task automatic do_reset(input logic chk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(posedge clk);
    #1;
    if (chk) begin
      @(negedge clk);
      check("rst_blk_valid", 512'(bus.blk_valid), 512'(0));
      check("rst_blk_data", bus.blk_data, 512'(0));
      check("rst_blk_first", 512'(bus.blk_first), 512'(0));
      check("rst_blk_last", 512'(bus.blk_last), 512'(0));
      check("rst_words_seen", 512'(bus.words_seen), 512'(0));
      check("rst_in_ready", 512'(bus.in_ready), 512'(0));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    cur.delete();
    m_total   = 0;
    m_first   = 1'b1;
    occ       = 0;
    prev_hold = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_s        vecs[$];
    int unsigned p0;
    int unsigned nxt;

    // {words in message (1..n, last on n), blocks out, last block slots 0/5/15}
`ifdef SHA_BLOCK_LOADER_PAD_EN
    vecs.push_back(vec_s'{1, 1, 32'd1, 32'd0, 32'h20});
    vecs.push_back(vec_s'{5, 1, 32'd1, 32'h8000_0000, 32'hA0});
    vecs.push_back(vec_s'{13, 1, 32'd1, 32'd6, 32'h1A0});
    vecs.push_back(vec_s'{14, 2, 32'd0, 32'd0, 32'h1C0});
    vecs.push_back(vec_s'{15, 2, 32'd0, 32'd0, 32'h1E0});
    vecs.push_back(vec_s'{16, 2, 32'h8000_0000, 32'd0, 32'h200});
    vecs.push_back(vec_s'{17, 2, 32'd17, 32'd0, 32'h220});
`else
    vecs.push_back(vec_s'{16, 1, 32'd1, 32'd6, 32'd16});
    vecs.push_back(vec_s'{5, 1, 32'd1, 32'd0, 32'd0});
    vecs.push_back(vec_s'{20, 2, 32'd17, 32'd0, 32'd0});
    vecs.push_back(vec_s'{32, 2, 32'd17, 32'd22, 32'd32});
    vecs.push_back(vec_s'{1, 1, 32'd1, 32'd0, 32'd0});
`endif

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_word   = '0;
    bus.in_last   = 1'b0;
    bus.blk_ready = 1'b0;
    do_reset(1'b1);
    cyc();
    check("post_rst_in_ready", 512'(ir_s), 512'(1));
    check("post_rst_blk_valid", 512'(bv_s), 512'(0));

    // 16 words 1..16: block visible the cycle after the 16th transfer.
    bus.blk_ready = 1'b1;
    p0 = pops;
    for (int i = 1; i <= 15; i++) send(32'(i), 1'b0);
    bus.in_valid = 1'b1;
    bus.in_word  = 32'd16;
    bus.in_last  = 1'b0;
    cyc();
    check("lat_accept", 512'(acc_s), 512'(1));
    check("lat_before", 512'(bv_s), 512'(0));
    bus.in_valid = 1'b0;
    cyc();
    check("lat_after", 512'(bv_s), 512'(1));
    check("lat_pops", 512'(pops - p0), 512'(1));
    check("lat_w0", 512'(wd(last_pop.data, 0)), 512'(32'd1));
    check("lat_w15", 512'(wd(last_pop.data, 15)), 512'(32'd16));
    check("lat_first", 512'(last_pop.first), 512'(1));

    foreach (vecs[k]) begin
      do_reset(1'b0);
      bus.blk_ready = 1'b1;
      p0 = pops;
      for (int i = 1; i <= int'(vecs[k].n); i++) send(32'(i), i == int'(vecs[k].n));
      wait_pops(p0 + vecs[k].nblk);
      repeat (3) cyc();
      check("tbl_nblk", 512'(pops - p0), 512'(vecs[k].nblk));
      check("tbl_last", 512'(last_pop.last), 512'(1));
      check("tbl_w0", 512'(wd(last_pop.data, 0)), 512'(vecs[k].w0));
      check("tbl_w5", 512'(wd(last_pop.data, 5)), 512'(vecs[k].w5));
      check("tbl_w15", 512'(wd(last_pop.data, 15)), 512'(vecs[k].w15));
      check("tbl_words_seen", 512'(bus.words_seen), 512'(0));
    end

    // Backpressure: two blocks fill the buffer, the third block's words stall.
    do_reset(1'b0);
    bus.blk_ready = 1'b0;
    nxt = 1;
    for (int c = 0; c < 40; c++) begin
      bus.in_valid = 1'b1;
      bus.in_word  = 32'(nxt);
      bus.in_last  = 1'b0;
      cyc();
      if (acc_s) nxt++;
    end
    bus.in_valid = 1'b0;
    check("bp_accepted", 512'(nxt - 1), 512'(32));
    check("bp_in_ready", 512'(ir_s), 512'(0));
    p0 = pops;
    bus.blk_ready = 1'b1;
    while (nxt <= 48) begin
      send(32'(nxt), 1'b0);
      nxt++;
    end
    wait_pops(p0 + 3);
    check("bp_w0", 512'(wd(last_pop.data, 0)), 512'(32'd33));
    check("bp_w15", 512'(wd(last_pop.data, 15)), 512'(32'd48));

    // Reset with one buffered block and 7 words in assembly.
    do_reset(1'b0);
    bus.blk_ready = 1'b0;
    for (int i = 1; i <= 23; i++) send(32'(i), 1'b0);
    do_reset(1'b1);
    cyc();
    check("mid_rst_blk_valid", 512'(bv_s), 512'(0));
    check("mid_rst_in_ready", 512'(ir_s), 512'(1));
    bus.blk_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 16; i++) send(32'h100 + 32'(i), 1'b0);
    wait_pops(p0 + 1);
    check("mid_first", 512'(last_pop.first), 512'(1));
    check("mid_w0", 512'(wd(last_pop.data, 0)), 512'(32'h100));
    check("mid_w6", 512'(wd(last_pop.data, 6)), 512'(32'h106));
    check("mid_w15", 512'(wd(last_pop.data, 15)), 512'(32'h10F));

`ifdef SHA_BLOCK_LOADER_PAD_EN
    do_reset(1'b0);
    bus.blk_ready = 1'b1;
    p0 = pops;
    send(32'h6162_6380, 1'b1);
    wait_pops(p0 + 1);
    check("pad_one_word", last_pop.data, {32'h6162_6380, 32'h8000_0000, 416'h0, 32'h20});
    check("pad_one_last", 512'(last_pop.last), 512'(1));

    do_reset(1'b0);
    p0 = pops;
    for (int i = 1; i <= 15; i++) send(32'(i), i == 15);
    bus.in_valid = 1'b1;
    bus.in_word  = 32'hDEAD_BEEF;
    cyc();
    check("pad_gap_in_ready", 512'(ir_s), 512'(0));
    bus.in_valid = 1'b0;
    wait_pops(p0 + 2);
    check("pad_gap_w15", 512'(wd(last_pop.data, 15)), 512'(32'h1E0));
`endif

    // Randomized traffic against the scoreboard.
    do_reset(1'b0);
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid  = ($urandom_range(9) < 7);
      bus.in_word   = $urandom();
      bus.in_last   = ($urandom_range(11) == 0);
      bus.blk_ready = ($urandom_range(9) < 6);
      cyc();
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.blk_ready = 1'b1;
    repeat (40) cyc();
    check("drain_empty", 512'(exp_q.size()), 512'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sha_block_loader.md
Name: sha_block_loader

Overview:
- Assembles a stream of message words into complete SHA-256 input blocks for the hashing core.
- Buffers up to DEPTH finished blocks so the input stream and the hash core are decoupled by valid/ready handshakes on both sides.
- Parametrised successor to the fixed 32-bit block lane: word width, words per block and buffer depth are configurable.
- Adds an optional hardware SHA message-padding mode.

Parameters:
- WORD_W, 32, width of one input word in bits.
- WORDS, 16, words per block; blk_data width = WORDS*WORD_W.
- DEPTH, 2, number of completed blocks held in the output buffer (>=1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_word/in_last valid this cycle.
- in_word  input  WORD_W  message word.
- in_last  input  1  marks the final word of a message.
- in_ready  output  1  loader accepts a word this cycle.
- blk_valid  output  1  blk_data/blk_first/blk_last valid.
- blk_data  output  WORDS*WORD_W  block; word 0 in the MSBs (big-endian order).
- blk_first  output  1  block is the first block of its message.
- blk_last  output  1  block is the final block of its message.
- blk_ready  input  1  consumer accepts the block this cycle.
- words_seen  output  64  running count of words accepted in the current message.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs go to 0.
  - Word index goes to 0, the buffer empties, first-flag is set, FSM goes to FILL.
  - A partial block or any buffered blocks are discarded.
  - Reset takes priority over every other event on the same edge.
- Handshakes:
  - Input transfer = in_valid & in_ready; output transfer = blk_valid & blk_ready.
  - blk_valid and blk_data must hold stable until the block is taken.
  - Buffer occupancy changes by push minus pop.
- Word capture:
  - Each input transfer writes in_word into slot idx of the assembly register, increments idx and increments words_seen (64-bit, wraps).
- Block completion:
  - Happens when idx reaches WORDS-1 with a transfer, or on a transfer with in_last=1.
  - The block is pushed into the buffer on the following edge, giving 1-cycle latency to blk_valid when the buffer is empty.
  - Unfilled slots are zero.
  - After the push: idx returns to 0, blk_first is copied from the first-flag, and the first-flag is cleared. If in_last=1, blk_last=1, the first-flag is set again and words_seen clears to 0.
- in_ready = (FSM==FILL) & (buffer occupancy < DEPTH, or a pop happens this cycle).
- Full buffer: in_ready=0; the assembly register holds its contents; no word is lost.
- Simultaneous push and pop on a full buffer: allowed; occupancy stays DEPTH.
- Buffer order is FIFO, with the read pointer wrapping modulo DEPTH.
- FSM states: FILL, PAD_ZERO, PAD_LEN. Only FILL is used without SHA_PAD_EN.

Optional Feature:
- Macro: SHA_BLOCK_LOADER_PAD_EN.
- When defined:
  - Supported only for WORD_W=32, WORDS=16; any other value is an elaboration error.
  - An in_last transfer places the word, then 0x80000000 in the next slot.
  - Message bit length L = words_seen*32, captured including the last word.
  - If that leaves at most 14 words used, slots up to 13 are zero and slots 14/15 = L[63:32]/L[31:0]. One block is emitted, with blk_last=1.
  - If more than 14 words are used, the current block is zero-filled and emitted with blk_last=0. The FSM then goes to PAD_ZERO, which builds an all-zero block, then PAD_LEN, which writes L into slots 14/15 and pushes that block with blk_last=1.
  - in_ready=0 outside FILL.
  - Return to FILL after the final push.
  - Word-count wrap beyond 2^58 words is unspecified.
- When not defined: no padding; partial blocks are zero-filled as described in Behaviour.

Test Plan:
- Reset then 16 words 0x00000001..0x00000010, blk_ready=1 → one block, blk_data MSB word 0x00000001, LSB word 0x00000010, blk_first=1, blk_valid one cycle after the 16th transfer.
- blk_ready=0, stream 3×16 words with DEPTH=2 → in_ready drops after the 2nd block completes; the 3rd block's words stall. Raising blk_ready yields all 3 blocks in order with no word lost.
- 5 words, the 5th with in_last, pad macro off → block with words 5..15 = 0, blk_first=1, blk_last=1; words_seen returns to 0.
- Pad macro on, message 0x61626380 (1 word, in_last) → slot1 = 0x80000000, slots 2..14 = 0, slot15 = 0x00000020.
- Pad macro on, 15 words with in_last → two blocks. First block has slot15 = 0x80000000 and blk_last=0. Second block is zero except slot15 = 0x000001E0, with blk_last=1. in_ready=0 between the two.
- rst asserted mid-block after 7 words and 1 buffered block → next cycle blk_valid=0 and in_ready=1. A new 16-word message produces a block with blk_first=1 containing only the new words.
